// File: rtl/tpu_pkg.sv
// Shared TPU datapath definitions: PE dataflow modes, default fixed-point format
// and saturation limits for a signed two's-complement width.
package tpu_pkg;

    typedef enum logic {
        PE_WS = 1'b0,
        PE_OS = 1'b1
    } pe_mode_e;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_FRAC_BITS  = 8;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/systolic_pe_v2_if.sv
// Neighbour-facing signal bundle of one systolic PE: west/north inputs, east/south outputs.
// master drives the PE inputs (array controller or neighbour); slave is the PE itself.
interface systolic_pe_v2_if #(
    parameter int DATA_WIDTH = tpu_pkg::DEFAULT_DATA_WIDTH
);
    logic                  pe_enable;
    logic                  pe_stall;
    logic                  pe_mode;
    logic [DATA_WIDTH-1:0] pe_input_in;
    logic                  pe_valid_in;
    logic [DATA_WIDTH-1:0] pe_weight_in;
    logic                  pe_accept_w_in;
    logic                  pe_switch_in;
    logic [DATA_WIDTH-1:0] pe_psum_in;
    logic [DATA_WIDTH-1:0] pe_input_out;
    logic                  pe_valid_out;
    logic [DATA_WIDTH-1:0] pe_weight_out;
    logic                  pe_accept_w_out;
    logic                  pe_switch_out;
    logic [DATA_WIDTH-1:0] pe_psum_out;
    logic                  pe_sat_out;

    modport master (
        output pe_enable, pe_stall, pe_mode,
        output pe_input_in, pe_valid_in, pe_weight_in, pe_accept_w_in, pe_switch_in, pe_psum_in,
        input  pe_input_out, pe_valid_out, pe_weight_out, pe_accept_w_out, pe_switch_out,
        input  pe_psum_out, pe_sat_out
    );

    modport slave (
        input  pe_enable, pe_stall, pe_mode,
        input  pe_input_in, pe_valid_in, pe_weight_in, pe_accept_w_in, pe_switch_in, pe_psum_in,
        output pe_input_out, pe_valid_out, pe_weight_out, pe_accept_w_out, pe_switch_out,
        output pe_psum_out, pe_sat_out
    );

endinterface

// File: rtl/fxp_mac_sat.sv
// Combinational fixed-point MAC: round-to-nearest multiply (optionally gated to zero)
// followed by a saturating add, with separate clamp flags for each stage.
module fxp_mac_sat
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
    input  logic signed [DATA_WIDTH-1:0] mul_a,
    input  logic signed [DATA_WIDTH-1:0] mul_b,
    input  logic                         mul_en,
    input  logic signed [DATA_WIDTH-1:0] add_x,
    output logic signed [DATA_WIDTH-1:0] prod,
    output logic signed [DATA_WIDTH-1:0] sum,
    output logic                         prod_sat,
    output logic                         add_sat
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [PW-1:0]         MAX_P = PW'(sat_max(DATA_WIDTH));
    localparam logic signed [PW-1:0]         MIN_P = PW'(sat_min(DATA_WIDTH));
    localparam logic signed [PW-1:0]         ROUND = PW'(longint'(1) <<< (FRAC_BITS - 1));
    localparam logic signed [DATA_WIDTH-1:0] MAX_D = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] MIN_D = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [PW-1:0]   full_prod;
    logic signed [PW-1:0]   rounded;
    logic [DATA_WIDTH:0]    wide_sum;

    // The full product plus the half-LSB cannot overflow PW bits, so rounding is exact.
    always_comb begin
        full_prod = PW'(mul_a) * PW'(mul_b);
        rounded   = (full_prod + ROUND) >>> FRAC_BITS;
        prod      = '0;
        prod_sat  = 1'b0;
        if (mul_en) begin
            if (rounded > MAX_P) begin
                prod     = MAX_D;
                prod_sat = 1'b1;
            end else if (rounded < MIN_P) begin
                prod     = MIN_D;
                prod_sat = 1'b1;
            end else begin
                prod = rounded[DATA_WIDTH-1:0];
            end
        end
    end

    // One guard bit: overflow shows as disagreement between the two top bits.
    always_comb begin
        wide_sum = {add_x[DATA_WIDTH-1], add_x} + {prod[DATA_WIDTH-1], prod};
        add_sat  = wide_sum[DATA_WIDTH] ^ wide_sum[DATA_WIDTH-1];
        if (add_sat) begin
            sum = wide_sum[DATA_WIDTH] ? MIN_D : MAX_D;
        end else begin
            sum = wide_sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_pe_v2.sv
// Systolic-array PE with runtime WS/OS dataflow, double-buffered weights, stall and
// synchronous enable-clear; one shared saturating MAC serves both dataflows.
module systolic_pe_v2
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst,
    systolic_pe_v2_if.slave  bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] input_out;
        logic [DATA_WIDTH-1:0] weight_out;
        logic [DATA_WIDTH-1:0] psum_out;
        logic [DATA_WIDTH-1:0] w_active;
        logic [DATA_WIDTH-1:0] w_shadow;
        logic [DATA_WIDTH-1:0] acc;
        logic                  valid_out;
        logic                  accept_w_out;
        logic                  switch_out;
        logic                  sat;
    } pe_state_t;

    pe_state_t state_reg;
    pe_state_t state_next;

    pe_mode_e              mode;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [DATA_WIDTH-1:0] mac_x;
    logic                  mac_en;
    logic [DATA_WIDTH-1:0] mac_prod;
    logic [DATA_WIDTH-1:0] mac_sum;
    logic                  mac_prod_sat;
    logic                  mac_add_sat;

    assign mode = pe_mode_e'(bus.pe_mode);

    // Operand mux: WS multiplies by the active weight and adds the incoming psum;
    // OS multiplies by the streaming weight and adds the local accumulator.
    always_comb begin
        mac_b  = state_reg.w_active;
        mac_x  = bus.pe_psum_in;
        mac_en = bus.pe_valid_in;
        if (mode == PE_OS) begin
            mac_b  = bus.pe_weight_in;
            mac_x  = state_reg.acc;
            mac_en = bus.pe_valid_in && bus.pe_accept_w_in;
        end
    end

    fxp_mac_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_mac (
        .mul_a    (bus.pe_input_in),
        .mul_b    (mac_b),
        .mul_en   (mac_en),
        .add_x    (mac_x),
        .prod     (mac_prod),
        .sum      (mac_sum),
        .prod_sat (mac_prod_sat),
        .add_sat  (mac_add_sat)
    );

    always_comb begin
        state_next              = state_reg;
        state_next.input_out    = bus.pe_valid_in ? bus.pe_input_in : '0;
        state_next.valid_out    = bus.pe_valid_in;
        state_next.accept_w_out = bus.pe_accept_w_in;
        state_next.switch_out   = bus.pe_switch_in;
        state_next.weight_out   = '0;
        state_next.psum_out     = bus.pe_psum_in;
        state_next.acc          = '0;
        state_next.sat          = 1'b0;

        if (mode == PE_OS) begin
            state_next.weight_out = bus.pe_weight_in;
            if (bus.pe_switch_in) begin
                // Drain: the accumulator leaves and this cycle's product starts the next one.
                state_next.psum_out = state_reg.acc;
                state_next.acc      = mac_prod;
                state_next.sat      = mac_prod_sat;
            end else begin
                state_next.acc = mac_sum;
                state_next.sat = mac_prod_sat | mac_add_sat;
            end
        end else begin
            if (bus.pe_accept_w_in) begin
                state_next.w_shadow   = bus.pe_weight_in;
                state_next.weight_out = bus.pe_weight_in;
            end
            // Reads the registered shadow, so a same-cycle load lands behind the swap.
            if (bus.pe_switch_in) begin
                state_next.w_active = state_reg.w_shadow;
            end
            if (bus.pe_valid_in) begin
                state_next.psum_out = mac_sum;
                state_next.sat      = mac_prod_sat | mac_add_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
        end else if (!bus.pe_enable) begin
            state_reg <= '0;
        end else if (!bus.pe_stall) begin
            state_reg <= state_next;
        end
    end

    assign bus.pe_input_out    = state_reg.input_out;
    assign bus.pe_valid_out    = state_reg.valid_out;
    assign bus.pe_weight_out   = state_reg.weight_out;
    assign bus.pe_accept_w_out = state_reg.accept_w_out;
    assign bus.pe_switch_out   = state_reg.switch_out;
    assign bus.pe_psum_out     = state_reg.psum_out;
    assign bus.pe_sat_out      = state_reg.sat;

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Scoreboard bench for systolic_pe_v2 at DW=16, F=8: expected psum/sat pushed when
// driven, popped one cycle later when the PE registers its result.
module tb_systolic_pe_v2;

    localparam int DW = 16;
    localparam int FB = 8;

    typedef struct {
        logic [DW-1:0] psum;
        logic          sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    systolic_pe_v2_if #(.DATA_WIDTH(DW)) bus ();

    systolic_pe_v2 #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.pe_enable      = 1'b1;
        bus.pe_stall       = 1'b0;
        bus.pe_valid_in    = 1'b0;
        bus.pe_input_in    = '0;
        bus.pe_weight_in   = '0;
        bus.pe_accept_w_in = 1'b0;
        bus.pe_switch_in   = 1'b0;
        bus.pe_psum_in     = '0;
    endtask

    task automatic push_exp(input logic [DW-1:0] p, input logic s);
        exp_t e;
        e.psum = p;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    // Independent reference: round-to-nearest multiply, then saturating add.
    function automatic void model_mac(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                      input logic [DW-1:0] x, output logic [DW-1:0] r,
                                      output logic s);
        longint p;
        longint t;
        bit     ps;
        bit     as;
        ps = 0;
        as = 0;
        p = (longint'($signed(a)) * longint'($signed(b)) + 128) >>> 8;
        if (p > 32767) begin p = 32767; ps = 1; end
        else if (p < -32768) begin p = -32768; ps = 1; end
        t = longint'($signed(x)) + p;
        if (t > 32767) begin t = 32767; as = 1; end
        else if (t < -32768) begin t = -32768; as = 1; end
        r = t[DW-1:0];
        s = ps | as;
    endfunction

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        set_idle();
        bus.pe_mode = 1'b0;
        repeat (2) tick();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== '0) begin
            errors++;
            $display("FAIL reset_psum got %h/%b exp 0000/0", bus.pe_psum_out, bus.pe_sat_out);
        end
        checks++;
        if ({bus.pe_input_out, bus.pe_valid_out, bus.pe_weight_out,
             bus.pe_accept_w_out, bus.pe_switch_out} !== '0) begin
            errors++;
            $display("FAIL reset_fwd got in=%h v=%b w=%h a=%b s=%b exp all 0", bus.pe_input_out,
                     bus.pe_valid_out, bus.pe_weight_out, bus.pe_accept_w_out, bus.pe_switch_out);
        end
        rst = 1'b0;
        tick();
        push_exp(16'h0000, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
            errors++;
            $display("FAIL reset_idle got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out, e.psum, e.sat);
        end
        $display("test_reset done");
    endtask

    task automatic test_ws_basic();
        exp_t e;
        set_idle();
        bus.pe_accept_w_in = 1'b1;
        bus.pe_weight_in   = 16'h0200;
        tick();
        checks++;
        if (bus.pe_weight_out !== 16'h0200 || bus.pe_accept_w_out !== 1'b1) begin
            errors++;
            $display("FAIL ws_load_fwd got w=%h a=%b exp 0200/1", bus.pe_weight_out, bus.pe_accept_w_out);
        end
        bus.pe_accept_w_in = 1'b0;
        bus.pe_weight_in   = 16'h0000;
        bus.pe_switch_in   = 1'b1;
        tick();
        checks++;
        if (bus.pe_switch_out !== 1'b1 || bus.pe_weight_out !== 16'h0000) begin
            errors++;
            $display("FAIL ws_switch_fwd got s=%b w=%h exp 1/0000", bus.pe_switch_out, bus.pe_weight_out);
        end
        bus.pe_switch_in = 1'b0;
        bus.pe_valid_in  = 1'b1;
        bus.pe_input_in  = 16'h0180;
        bus.pe_psum_in   = 16'h0100;
        push_exp(16'h0400, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
            errors++;
            $display("FAIL ws_basic got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out, e.psum, e.sat);
        end
        checks++;
        if (bus.pe_input_out !== 16'h0180 || bus.pe_valid_out !== 1'b1) begin
            errors++;
            $display("FAIL ws_input_fwd got %h/%b exp 0180/1", bus.pe_input_out, bus.pe_valid_out);
        end
        bus.pe_valid_in = 1'b0;
        bus.pe_input_in = 16'h5555;
        bus.pe_psum_in  = 16'h1234;
        push_exp(16'h1234, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out, bus.pe_input_out, bus.pe_valid_out} !==
            {e.psum, e.sat, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL ws_passthru got %h/%b in=%h v=%b exp %h/%b in=0000 v=0", bus.pe_psum_out,
                     bus.pe_sat_out, bus.pe_input_out, bus.pe_valid_out, e.psum, e.sat);
        end
        $display("test_ws_basic done");
    endtask

    task automatic test_ws_collision();
        exp_t e;
        logic [DW-1:0] in_v[3]  = '{16'h0200, 16'h0000, 16'h0200};
        logic          val_v[3] = '{1'b1, 1'b0, 1'b1};
        logic          sw_v[3]  = '{1'b0, 1'b1, 1'b0};
        logic [DW-1:0] exp_v[3] = '{16'h0200, 16'h0000, 16'h0600};
        set_idle();
        bus.pe_accept_w_in = 1'b1;
        bus.pe_weight_in   = 16'h0100;
        tick();
        bus.pe_weight_in   = 16'h0300;
        bus.pe_switch_in   = 1'b1;
        tick();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            bus.pe_input_in  = in_v[i];
            bus.pe_valid_in  = val_v[i];
            bus.pe_switch_in = sw_v[i];
            push_exp(exp_v[i], 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
                errors++;
                $display("FAIL ws_collision[%0d] got %h/%b exp %h/%b", i, bus.pe_psum_out,
                         bus.pe_sat_out, e.psum, e.sat);
            end
        end
        $display("test_ws_collision done");
    endtask

    task automatic test_saturation();
        exp_t e;
        logic [DW-1:0] w_v[2]   = '{16'h7FFF, 16'h0100};
        logic [DW-1:0] in_v[2]  = '{16'h7FFF, 16'h8000};
        logic [DW-1:0] ps_v[2]  = '{16'h0000, 16'h8000};
        logic [DW-1:0] exp_v[2] = '{16'h7FFF, 16'h8000};
        for (int i = 0; i < 2; i++) begin
            set_idle();
            bus.pe_accept_w_in = 1'b1;
            bus.pe_weight_in   = w_v[i];
            tick();
            set_idle();
            bus.pe_switch_in = 1'b1;
            tick();
            set_idle();
            bus.pe_valid_in = 1'b1;
            bus.pe_input_in = in_v[i];
            bus.pe_psum_in  = ps_v[i];
            push_exp(exp_v[i], 1'b1);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
                errors++;
                $display("FAIL saturation[%0d] got %h/%b exp %h/%b", i, bus.pe_psum_out,
                         bus.pe_sat_out, e.psum, e.sat);
            end
        end
        $display("test_saturation done");
    endtask

    task automatic test_stall();
        exp_t e;
        set_idle();
        bus.pe_valid_in = 1'b1;
        bus.pe_input_in = 16'h0300;
        bus.pe_psum_in  = 16'h0010;
        push_exp(16'h0310, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
            errors++;
            $display("FAIL stall_pre got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out, e.psum, e.sat);
        end
        // Everything driven during the stall, including a load and a swap, must be ignored.
        bus.pe_stall       = 1'b1;
        bus.pe_input_in    = 16'h7FFF;
        bus.pe_psum_in     = 16'h7000;
        bus.pe_accept_w_in = 1'b1;
        bus.pe_weight_in   = 16'h4000;
        bus.pe_switch_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out, bus.pe_input_out, bus.pe_valid_out,
                 bus.pe_weight_out, bus.pe_accept_w_out, bus.pe_switch_out} !==
                {16'h0310, 1'b0, 16'h0300, 1'b1, 16'h0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d] got p=%h in=%h v=%b w=%h a=%b s=%b exp p=0310 in=0300 v=1 w=0000 a=0 s=0",
                         i, bus.pe_psum_out, bus.pe_input_out, bus.pe_valid_out,
                         bus.pe_weight_out, bus.pe_accept_w_out, bus.pe_switch_out);
            end
        end
        set_idle();
        bus.pe_valid_in = 1'b1;
        bus.pe_input_in = 16'h0200;
        push_exp(16'h0200, 1'b0);
        tick();
        set_idle();
        bus.pe_switch_in = 1'b1;
        push_exp(16'h0000, 1'b0);
        tick();
        set_idle();
        bus.pe_valid_in = 1'b1;
        bus.pe_input_in = 16'h0200;
        push_exp(16'h0200, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (i == 2 && {bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
                errors++;
                $display("FAIL stall_resume got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out,
                         e.psum, e.sat);
            end
        end
        $display("test_stall done");
    endtask

    task automatic test_back_to_back();
        exp_t          e;
        logic [DW-1:0] active;
        logic [DW-1:0] shadow;
        logic [DW-1:0] r;
        logic          s;
        set_idle();
        bus.pe_mode   = 1'b0;
        bus.pe_enable = 1'b0;
        tick();
        active = '0;
        shadow = '0;
        for (int i = 0; i < 40; i++) begin
            set_idle();
            bus.pe_valid_in    = ($urandom_range(0, 3) != 0);
            bus.pe_input_in    = DW'($urandom);
            bus.pe_psum_in     = DW'($urandom);
            bus.pe_accept_w_in = ($urandom_range(0, 3) == 0);
            bus.pe_weight_in   = DW'($urandom);
            bus.pe_switch_in   = ($urandom_range(0, 4) == 0);
            if (bus.pe_valid_in) model_mac(bus.pe_input_in, active, bus.pe_psum_in, r, s);
            else begin r = bus.pe_psum_in; s = 1'b0; end
            push_exp(r, s);
            if (bus.pe_switch_in) active = shadow;
            if (bus.pe_accept_w_in) shadow = bus.pe_weight_in;
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
                errors++;
                $display("FAIL b2b[%0d] got %h/%b exp %h/%b", i, bus.pe_psum_out, bus.pe_sat_out,
                         e.psum, e.sat);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_os_accumulate();
        exp_t e;
        logic          sw_v[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic          val_v[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] w_v[6]   = '{16'h0200, 16'h0200, 16'h0200, 16'h0100, 16'h0000, 16'h0000};
        logic [DW-1:0] ps_v[6]  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0055};
        logic [DW-1:0] exp_v[6] = '{16'h0000, 16'h0000, 16'h0000, 16'h0600, 16'h0100, 16'h0055};
        set_idle();
        bus.pe_enable = 1'b0;
        bus.pe_mode   = 1'b1;
        tick();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out, bus.pe_input_out, bus.pe_weight_out} !== '0) begin
            errors++;
            $display("FAIL enable_clear got p=%h s=%b in=%h w=%h exp all 0", bus.pe_psum_out,
                     bus.pe_sat_out, bus.pe_input_out, bus.pe_weight_out);
        end
        for (int i = 0; i < 6; i++) begin
            set_idle();
            bus.pe_valid_in    = val_v[i];
            bus.pe_accept_w_in = val_v[i];
            bus.pe_input_in    = val_v[i] ? 16'h0100 : 16'h0000;
            bus.pe_weight_in   = w_v[i];
            bus.pe_switch_in   = sw_v[i];
            bus.pe_psum_in     = ps_v[i];
            push_exp(exp_v[i], 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out, bus.pe_weight_out} !== {e.psum, e.sat, w_v[i]}) begin
                errors++;
                $display("FAIL os_acc[%0d] got %h/%b w=%h exp %h/%b w=%h", i, bus.pe_psum_out,
                         bus.pe_sat_out, bus.pe_weight_out, e.psum, e.sat, w_v[i]);
            end
        end
        $display("test_os_accumulate done");
    endtask

    task automatic test_enable_clear();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            set_idle();
            bus.pe_valid_in    = 1'b1;
            bus.pe_accept_w_in = 1'b1;
            bus.pe_input_in    = 16'h0100;
            bus.pe_weight_in   = 16'h0100;
            bus.pe_psum_in     = 16'h0011;
            tick();
        end
        bus.pe_enable = 1'b0;
        tick();
        checks++;
        if ({bus.pe_psum_out, bus.pe_input_out, bus.pe_valid_out, bus.pe_weight_out,
             bus.pe_accept_w_out} !== '0) begin
            errors++;
            $display("FAIL enable_outputs got p=%h in=%h v=%b w=%h a=%b exp all 0", bus.pe_psum_out,
                     bus.pe_input_out, bus.pe_valid_out, bus.pe_weight_out, bus.pe_accept_w_out);
        end
        set_idle();
        bus.pe_switch_in = 1'b1;
        push_exp(16'h0000, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
            errors++;
            $display("FAIL enable_acc got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out, e.psum, e.sat);
        end
        $display("test_enable_clear done");
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            set_idle();
            bus.pe_valid_in    = 1'b1;
            bus.pe_accept_w_in = 1'b1;
            bus.pe_input_in    = 16'h0100;
            bus.pe_weight_in   = 16'h0200;
            bus.pe_psum_in     = 16'h0077;
            push_exp(16'h0077, 1'b0);
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
                errors++;
                $display("FAIL areset_pre[%0d] got %h/%b exp %h/%b", i, bus.pe_psum_out,
                         bus.pe_sat_out, e.psum, e.sat);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out, bus.pe_input_out, bus.pe_valid_out,
             bus.pe_weight_out, bus.pe_accept_w_out, bus.pe_switch_out} !== '0) begin
            errors++;
            $display("FAIL areset_now got p=%h in=%h v=%b w=%h a=%b exp all 0", bus.pe_psum_out,
                     bus.pe_input_out, bus.pe_valid_out, bus.pe_weight_out, bus.pe_accept_w_out);
        end
        #1;
        rst = 1'b0;
        set_idle();
        bus.pe_switch_in = 1'b1;
        push_exp(16'h0000, 1'b0);
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({bus.pe_psum_out, bus.pe_sat_out} !== {e.psum, e.sat}) begin
            errors++;
            $display("FAIL areset_drain got %h/%b exp %h/%b", bus.pe_psum_out, bus.pe_sat_out, e.psum, e.sat);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_ws_basic();
        test_ws_collision();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_os_accumulate();
        test_enable_clear();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
